ser_tx_arbiter: RTL and testbench
=================================

# ser_tx_arbiter

Round-robin transmit controller that shares one serial link among N_REQ parallel-word requesters and feeds the team's `deserializer` block. It accepts one DESER_W-bit word at a time from the winning requester and shifts it out MSB first on `ser_data_o`/`ser_data_val_o`. After each word it inserts the idle gap the deserializer needs to re-arm. It sits between the word-producing sources and the deserializer input (`data_i`/`data_val_i`).

## Interface
- DESER_W, 16: word width in bits; must equal the downstream deserializer's DESER_W; >= 2.
- N_REQ, 4: number of requesters; >= 2.
- GAP_CYCLES, 2: idle cycles after each word with `ser_data_val_o` low; >= 1.
- clk_i  input  1  single clock, all logic rising-edge.
- srst_i  input  1  reset, asynchronous, active-high.
- enable_i  input  1  when low, no new word is granted; a word already shifting completes.
- req_val_i  input  N_REQ  per-requester word valid.
- req_data_i  input  N_REQ*DESER_W  requester k word at bits [k*DESER_W +: DESER_W].
- req_ready_o  output  N_REQ  one-hot accept strobe; word k transfers when `req_val_i[k] & req_ready_o[k]`.
- ser_data_o  output  1  serial data, MSB of word first.
- ser_data_val_o  output  1  serial bit valid.
- grant_id_o  output  $clog2(N_REQ)  index of requester whose word is shifting; meaningful while `busy_o`.
- busy_o  output  1  high in SHIFT and GAP states.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - If `enable_i` and any `req_val_i` bit is set, a winner is chosen round-robin. The search starts at (last_grant+1) mod N_REQ and wraps.
  - `req_ready_o[winner]` is asserted combinationally in the same cycle; all other bits are 0.
  - On that edge: the word is loaded into the shift register, `grant_id_o` and last_grant take the winner index, the bit counter clears, and the state moves to SHIFT.
  - With no valid request, or with `enable_i` low, the block stays in IDLE and `req_ready_o` is 0.
- SHIFT:
  - `ser_data_o` = shift register MSB; `ser_data_val_o` = 1.
  - Each cycle the register shifts left one bit (zero fill) and the counter increments.
  - When the counter reaches DESER_W-1, the next state is GAP with a gap counter of 0.
- GAP:
  - `ser_data_val_o` = 0 and `ser_data_o` = 0.
  - Stays for GAP_CYCLES cycles, then returns to IDLE.
- `req_ready_o` is 0 outside IDLE.
  - A requester may hold `req_val_i` high indefinitely.
  - Data must be stable while `req_val_i` is high, until accepted.
  - Deasserting `req_val_i` before acceptance is legal; no word is taken.
- Changes to `enable_i` during SHIFT or GAP have no effect until IDLE.
- Counter widths: bit counter is $clog2(DESER_W) bits; gap counter is $clog2(GAP_CYCLES+1) bits. Neither wraps in normal operation.
- All outputs except `req_ready_o` are driven directly from flops.

## Timing
- Reset values, asserted asynchronously and immediately:
  - state IDLE; `ser_data_o` 0; `ser_data_val_o` 0; `grant_id_o` 0; `busy_o` 0; shift register 0.
  - last_grant = N_REQ-1, so requester 0 has first priority after reset.
- Reset mid-word: `ser_data_val_o` drops immediately and the partial word is discarded. The deserializer is reset by the same reset.
- Acceptance edge E0:
  - `ser_data_val_o` is high with bit DESER_W-1 in the cycle after E0.
  - Bit 0 is on the line DESER_W cycles after E0.
- Word period with continuous requests: 1 (IDLE) + DESER_W + GAP_CYCLES cycles. Default is 19.
  - Consecutive words are separated by GAP_CYCLES+1 idle cycles.
  - This guarantees at least 1 idle cycle for the deserializer's re-arm cycle.
- A single persistent requester receives every slot. With two active requesters, grants alternate strictly.
- Simultaneous `srst_i` and request: reset wins; no acceptance occurs.

## Test plan
- Reset, then `req_val_i`=0001 with word 0xA5C3 held: `req_ready_o`=0001 in the first IDLE cycle. Next 16 cycles carry bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 with valid high. Then 3 idle cycles, and a downstream deserializer reports 0xA5C3.
- All four requesters valid continuously with words 0x1111, 0x2222, 0x3333, 0x4444: grants are 0,1,2,3,0 with `grant_id_o` matching. Period is 19 cycles and the deserializer outputs the words in that order.
- `req_val_i`=0110 continuously: grants alternate 1,2,1,2; requesters 0 and 3 never get `req_ready_o`.
- `enable_i` dropped at bit 5 of a word: that word completes all 16 bits and the block stays IDLE with `req_ready_o`=0. Re-raising `enable_i` grants within 1 cycle.
- `srst_i` pulsed asynchronously, mid-clock, at bit 8: `ser_data_val_o`/`busy_o` go 0 without waiting for an edge. After release, requester 0 wins a tie against requester 2.
- `req_val_i[3]` raised for 1 cycle during GAP only, then low: no grant occurs and the block remains IDLE.

Source files
------------

// File: rtl/ser_tx_arbiter.sv
// ser_tx_arbiter
//
// Round-robin transmit controller. Several requesters offer parallel words; one
// winner at a time is accepted and its word is shifted out MSB first on a single
// serial line, followed by an idle gap so the downstream deserializer can re-arm.
//
// Ports:
//   clk_i           clock, rising edge
//   srst_i          asynchronous active-high reset
//   enable_i        gates new grants only; a word in flight always completes
//   req_val_i       per-requester word valid
//   req_data_i      requester k word at [k*DESER_W +: DESER_W]
//   req_ready_o     one-hot accept strobe (combinational, IDLE only)
//   ser_data_o      serial data, MSB first
//   ser_data_val_o  serial bit valid
//   grant_id_o      index of the requester whose word is shifting
//   busy_o          high while shifting or in the post-word gap

module ser_tx_arbiter #(
    parameter int unsigned DESER_W    = 16,
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       enable_i,
    input  logic [N_REQ-1:0]           req_val_i,
    input  logic [N_REQ*DESER_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic                       ser_data_o,
    output logic                       ser_data_val_o,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic                       busy_o
);

    localparam int unsigned GW  = $clog2(N_REQ);
    localparam int unsigned CW  = $clog2(DESER_W);
    localparam int unsigned GCW = $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0]  LastBit = CW'(DESER_W - 1);
    localparam logic [GCW-1:0] LastGap = GCW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0]  LastReq = GW'(N_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e             state_q;
    logic [DESER_W-1:0] shift_q;
    logic [CW-1:0]      bit_cnt_q;
    logic [GCW-1:0]     gap_cnt_q;
    logic [GW-1:0]      last_grant_q;

    logic [GW-1:0]      winner;
    logic [GW-1:0]      idx;
    logic               found;
    logic               grant_ok;

    // Round-robin search starting just after the previous winner, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = GW'((32'(last_grant_q) + i) % N_REQ);
            if (!found && req_val_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign grant_ok = (state_q == StIdle) && enable_i && found;

    // Masked by reset so a requester never sees an accept while reset is held.
    assign req_ready_o = (grant_ok && !srst_i) ? (N_REQ'(1) << winner) : '0;

    // Zero fill means the register is already empty once the last bit has left,
    // so the MSB is 0 throughout GAP and IDLE without extra muxing.
    assign ser_data_o = shift_q[DESER_W-1];

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q        <= StIdle;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            last_grant_q   <= LastReq;
            grant_id_o     <= '0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_ok) begin
                        shift_q        <= req_data_i[winner*DESER_W +: DESER_W];
                        grant_id_o     <= winner;
                        last_grant_q   <= winner;
                        bit_cnt_q      <= '0;
                        ser_data_val_o <= 1'b1;
                        busy_o         <= 1'b1;
                        state_q        <= StShift;
                    end
                end
                StShift: begin
                    shift_q <= {shift_q[DESER_W-2:0], 1'b0};
                    if (bit_cnt_q == LastBit) begin
                        gap_cnt_q      <= '0;
                        ser_data_val_o <= 1'b0;
                        state_q        <= StGap;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == LastGap) begin
                        busy_o  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_tx_arbiter.sv
module tb_ser_tx_arbiter;

    localparam int W = 16;
    localparam int N = 4;
    localparam int G = 2;

    logic           clk;
    logic           srst;
    logic           enable;
    logic [N-1:0]   req_val;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           ser_data;
    logic           ser_val;
    logic [1:0]     grant_id;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ser_tx_arbiter #(
        .DESER_W   (W),
        .N_REQ     (N),
        .GAP_CYCLES(G)
    ) dut (
        .clk_i         (clk),
        .srst_i        (srst),
        .enable_i      (enable),
        .req_val_i     (req_val),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .ser_data_o    (ser_data),
        .ser_data_val_o(ser_val),
        .grant_id_o    (grant_id),
        .busy_o        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural deserializer: collects valid bits MSB first into words.
    logic [W-1:0] des_sh = '0;
    int           des_cnt = 0;
    logic [W-1:0] rx_q[$];

    always @(negedge clk) begin
        if (srst) begin
            des_cnt = 0;
        end else if (ser_val) begin
            des_sh = {des_sh[W-2:0], ser_data};
            des_cnt++;
            if (des_cnt == W) begin
                rx_q.push_back(des_sh);
                des_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        srst    = 1'b1;
        req_val = '0;
        enable  = 1'b0;
        repeat (2) tick();
        srst = 1'b0;
    endtask

    // Returns at negedge+1 of the cycle in which req_ready_o is non-zero.
    task automatic wait_ready(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout waiting for req_ready_o", name);
        end
    endtask

    typedef struct {
        logic [3:0] val;
        logic [7:0] g;  // four 2-bit grant indices, first grant in [1:0]
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit           ok;
        int           base;
        int           t_prev;
        int           nval;
        bit           saw_ready;
        logic [W-1:0] word;
        logic [1:0]   line_q[$];
        logic [1:0]   sym;
        bit           idle;
        int           last;
        logic [1:0]   exp_gid;
        logic [N-1:0] exp_ready;
        logic [N-1:0] acc_prev;

        vecs[0] = '{val: 4'b0001, g: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[1] = '{val: 4'b1111, g: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[2] = '{val: 4'b0110, g: {2'd2, 2'd1, 2'd2, 2'd1}};
        vecs[3] = '{val: 4'b1010, g: {2'd3, 2'd1, 2'd3, 2'd1}};
        vecs[4] = '{val: 4'b1000, g: {2'd3, 2'd3, 2'd3, 2'd3}};
        vecs[5] = '{val: 4'b0101, g: {2'd2, 2'd0, 2'd2, 2'd0}};

        srst     = 1'b0;
        enable   = 1'b0;
        req_val  = '0;
        req_data = '0;

        // Asynchronous reset assertion before any clock edge has cleared state.
        tick();
        #2 srst = 1'b1;
        #1;
        chk("async_rst_val", 32'(ser_val), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        do_reset();

        // Reset state.
        #1;
        chk("rst_ser_data", 32'(ser_data), 32'd0);
        chk("rst_ser_val", 32'(ser_val), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // Single word 0xA5C3 bit by bit.
        base = rx_q.size();
        word = 16'hA5C3;
        req_data[15:0] = word;
        req_val = 4'b0001;
        enable  = 1'b1;
        #1;
        chk("a5c3_ready", 32'(req_ready), 32'h1);
        tick();
        req_val = '0;
        for (int i = 0; i < W; i++) begin
            #1;
            chk("a5c3_val", 32'(ser_val), 32'd1);
            chk("a5c3_bit", 32'(ser_data), 32'(word[W-1-i]));
            tick();
        end
        for (int i = 0; i < G + 1; i++) begin
            #1;
            chk("a5c3_gap_val", 32'(ser_val), 32'd0);
            chk("a5c3_gap_busy", 32'(busy), (i < G) ? 32'd1 : 32'd0);
            tick();
        end
        chk("a5c3_rx_cnt", 32'(rx_q.size()), 32'(base + 1));
        if (rx_q.size() > base) chk("a5c3_rx_word", 32'(rx_q[base]), 32'hA5C3);

        // Table: continuous requests, expected grant order and 19-cycle period.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
            enable   = 1'b1;
            req_val  = vecs[v].val;
            base     = rx_q.size();
            t_prev   = 0;
            for (int g = 0; g < 4; g++) begin
                wait_ready("tbl_wait", ok);
                if (!ok) break;
                chk("tbl_ready", 32'(req_ready), 32'(4'b0001 << vecs[v].g[2*g +: 2]));
                if (g > 0) chk("tbl_period", 32'(cyc - t_prev), 32'(1 + W + G));
                t_prev = cyc;
                tick();
                if (g == 3) req_val = '0;
                #1;
                chk("tbl_grant_id", 32'(grant_id), 32'(vecs[v].g[2*g +: 2]));
                chk("tbl_busy", 32'(busy), 32'd1);
            end
            repeat (W + G + 2) tick();
            chk("tbl_rx_cnt", 32'(rx_q.size()), 32'(base + 4));
            for (int g = 0; g < 4; g++) begin
                if (rx_q.size() > base + g)
                    chk("tbl_rx_word", 32'(rx_q[base+g]),
                        32'(req_data[vecs[v].g[2*g +: 2]*W +: W]));
            end
        end

        // enable_i dropped at bit 5: word completes, no further grant.
        do_reset();
        req_data[15:0] = 16'h1234;
        req_val = 4'b0001;
        enable  = 1'b1;
        #1;
        chk("en_ready0", 32'(req_ready), 32'h1);
        tick();
        nval = 0;
        saw_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) enable = 1'b0;
            #1;
            if (ser_val) nval++;
            if (i >= 5 && req_ready != '0) saw_ready = 1'b1;
            tick();
        end
        chk("en_bits", 32'(nval), 32'(W));
        chk("en_no_ready", 32'(saw_ready), 32'd0);
        chk("en_idle_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        #1;
        chk("en_regrant", 32'(req_ready), 32'h1);
        tick();
        req_val = '0;
        repeat (W + G + 2) tick();

        // Async reset mid-word at bit 8, then tie 0 vs 2 after release.
        do_reset();
        req_data = {16'h0000, 16'h0F0F, 16'h0000, 16'hBEEF};
        req_val = 4'b0001;
        enable  = 1'b1;
        tick();
        repeat (8) tick();
        #1;
        chk("mid_val_before", 32'(ser_val), 32'd1);
        #1 srst = 1'b1;
        req_val = 4'b0101;
        #1;
        chk("mid_rst_val", 32'(ser_val), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(ser_data), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        #1;
        chk("mid_rst_hold_busy", 32'(busy), 32'd0);
        tick();
        base = rx_q.size();
        srst = 1'b0;
        #1;
        chk("mid_tie_ready", 32'(req_ready), 32'h1);
        tick();
        req_val = '0;
        #1;
        chk("mid_tie_gid", 32'(grant_id), 32'd0);
        repeat (W + G + 2) tick();
        chk("mid_rx_cnt", 32'(rx_q.size()), 32'(base + 1));
        if (rx_q.size() > base) chk("mid_rx_word", 32'(rx_q[base]), 32'hBEEF);

        // Request pulsed only during GAP: nothing is taken.
        do_reset();
        req_val = 4'b0001;
        enable  = 1'b1;
        tick();
        req_val = '0;
        repeat (W) tick();
        req_val = 4'b1000;
        #1;
        chk("gap_ready", 32'(req_ready), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        tick();
        req_val = '0;
        tick();
        saw_ready = 1'b0;
        nval = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (req_ready != '0 || busy || ser_val) saw_ready = 1'b1;
            tick();
        end
        chk("gap_no_grant", 32'(saw_ready), 32'd0);

        // Randomized traffic against a line-level reference model.
        do_reset();
        line_q.delete();
        last     = N - 1;
        exp_gid  = '0;
        acc_prev = '0;
        for (int c = 0; c < 3000; c++) begin
            idle = (line_q.size() == 0);
            sym  = idle ? 2'b00 : line_q.pop_front();
            chk("rnd_val", 32'(ser_val), 32'(sym[1]));
            chk("rnd_data", 32'(ser_data), 32'(sym[0]));
            chk("rnd_busy", 32'(busy), idle ? 32'd0 : 32'd1);
            if (!idle) chk("rnd_gid", 32'(grant_id), 32'(exp_gid));
            for (int k = 0; k < N; k++) begin
                if (req_val[k] && !acc_prev[k]) begin
                    if ($urandom_range(15) == 0) req_val[k] = 1'b0;
                end else begin
                    req_val[k] = ($urandom_range(2) == 0);
                    req_data[k*W +: W] = W'($urandom);
                end
            end
            enable = ($urandom_range(9) != 0);
            #1;
            exp_ready = '0;
            if (idle && enable && req_val != '0) begin
                for (int i = 1; i <= N; i++) begin
                    int k;
                    k = (last + i) % N;
                    if (req_val[k]) begin
                        exp_ready = N'(1) << k;
                        last = k;
                        exp_gid = 2'(k);
                        for (int b = W - 1; b >= 0; b--)
                            line_q.push_back({1'b1, req_data[k*W + b]});
                        for (int z = 0; z < G; z++) line_q.push_back(2'b00);
                        break;
                    end
                end
            end
            chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            acc_prev = exp_ready;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
